// File: rtl/vel_ramp_generator_if.sv
// Command channel into the velocity ramp generator: target velocity plus per-tick step.
// Latency: none, this is wiring only.
// Backpressure: cmd_ready from the slave; a beat transfers when cmd_valid && cmd_ready.
//   cmd_valid      : command present (master -> slave)
//   cmd_ready      : slave can take a command (slave -> master)
//   cmd_target_vel : signed 32-bit target velocity, counts per tick
//   cmd_accel      : unsigned 16-bit per-tick step magnitude, 0 = jump straight to target
interface vel_ramp_generator_if;
    logic               cmd_valid;
    logic               cmd_ready;
    logic signed [31:0] cmd_target_vel;
    logic        [15:0] cmd_accel;

    modport master (
        output cmd_valid,
        output cmd_target_vel,
        output cmd_accel,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_target_vel,
        input  cmd_accel,
        output cmd_ready
    );
endinterface

// File: rtl/vel_ramp_generator.sv
// Acceleration-limited velocity setpoint generator with a fixed-rate controlled stop.
// Latency: accept -> LOAD for one cycle -> first step on the next control tick (jump when step is 0).
// Backpressure: cmd_ready is high only in IDLE and RAMP; stop_req overrides and discards commands.
//   clk, reset       : system clock, asynchronous active-high reset
//   cmd              : command channel (slave side)
//   stop_req         : level stop request, ramps the setpoint to 0 at STOP_STEP per tick
//   desired_vel      : registered setpoint to the velocity loop
//   busy/at_target/stopping : state decodes; tick : one-cycle control tick strobe
module vel_ramp_generator #(
    parameter int UPDATE_DIV = 5000,
    parameter int STOP_STEP  = 64
) (
    input  logic               clk,
    input  logic               reset,
    vel_ramp_generator_if.slave cmd,
    input  logic               stop_req,
    output logic signed [31:0] desired_vel,
    output logic               busy,
    output logic               at_target,
    output logic               stopping,
    output logic               tick
);

    localparam int              CW          = $clog2(UPDATE_DIV);
    localparam logic [CW-1:0]   CNT_LAST    = CW'(UPDATE_DIV - 1);
    localparam logic [15:0]     STOP_STEP_W = 16'(STOP_STEP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RAMP = 2'd2,
        STOP = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic signed [31:0] tgt, tgt_nxt;
    logic [15:0]        step, step_nxt;
    logic signed [31:0] dv_nxt;
    logic signed [31:0] ramp_val;
    logic signed [31:0] stop_val;
    logic               accept;

    // One slew step from cur toward tgt_v. The difference is formed at 33 bits so
    // full-scale swings (e.g. min to max int) cannot wrap; once |diff| exceeds the
    // step, cur +/- step lies strictly between cur and the target and fits in 32 bits.
    function automatic logic signed [31:0] slew(
        input logic signed [31:0] cur,
        input logic signed [31:0] tgt_v,
        input logic        [15:0] stp
    );
        logic signed [32:0] diff;
        logic signed [32:0] mag;
        diff = {tgt_v[31], tgt_v} - {cur[31], cur};
        mag  = diff[32] ? -diff : diff;
        if ($unsigned(mag) <= {17'd0, stp})
            slew = tgt_v;
        else if (diff[32])
            slew = cur - $signed({16'd0, stp});
        else
            slew = cur + $signed({16'd0, stp});
    endfunction

    // Free-running tick divider; never restarted by commands or stop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (cnt == CNT_LAST)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    assign tick     = (cnt == CNT_LAST);
    assign ramp_val = slew(desired_vel, tgt, step);
    assign stop_val = slew(desired_vel, 32'sd0, STOP_STEP_W);

    assign cmd.cmd_ready = (state == IDLE) || (state == RAMP);
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;

    assign busy      = (state != IDLE);
    assign at_target = (state == IDLE);
    assign stopping  = (state == STOP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            desired_vel <= '0;
            tgt         <= '0;
            step        <= '0;
        end else begin
            state       <= state_nxt;
            desired_vel <= dv_nxt;
            tgt         <= tgt_nxt;
            step        <= step_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        dv_nxt    = desired_vel;
        tgt_nxt   = tgt;
        step_nxt  = step;

        case (state)
            IDLE: begin
                if (accept) begin
                    tgt_nxt   = cmd.cmd_target_vel;
                    step_nxt  = cmd.cmd_accel;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (tgt == desired_vel) begin
                    state_nxt = IDLE;
                end else if (step == 16'd0) begin
                    dv_nxt    = tgt;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = RAMP;
                end
            end
            RAMP: begin
                if (tick) begin
                    dv_nxt = ramp_val;
                    if (ramp_val == tgt)
                        state_nxt = IDLE;
                end
                // Retarget starts from whatever desired_vel holds now; no jump.
                if (accept) begin
                    tgt_nxt   = cmd.cmd_target_vel;
                    step_nxt  = cmd.cmd_accel;
                    state_nxt = LOAD;
                end
            end
            STOP: begin
                if (tick)
                    dv_nxt = stop_val;
                if ((desired_vel == 32'sd0) && !stop_req)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // Stop wins over everything: a command accepted this cycle is dropped
        // without touching target/step, and the LOAD jump is cancelled.
        if (stop_req) begin
            state_nxt = STOP;
            tgt_nxt   = tgt;
            step_nxt  = step;
            if (state == LOAD)
                dv_nxt = desired_vel;
        end
    end

endmodule

// File: tb/tb_vel_ramp_generator.sv
module tb_vel_ramp_generator;

    localparam int UDIV  = 4;
    localparam int SSTEP = 64;
    localparam logic signed [31:0] VMAX = 32'sh7FFFFFFF;
    localparam logic signed [31:0] VMIN = 32'sh80000000;

    logic               clk = 1'b0;
    logic               reset;
    logic               stop_req;
    logic signed [31:0] desired_vel;
    logic               busy, at_target, stopping, tick;

    vel_ramp_generator_if cmd_if ();

    vel_ramp_generator #(.UPDATE_DIV(UDIV), .STOP_STEP(SSTEP)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd        (cmd_if),
        .stop_req   (stop_req),
        .desired_vel(desired_vel),
        .busy       (busy),
        .at_target  (at_target),
        .stopping   (stopping),
        .tick       (tick)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic signed [31:0] exp_q[$];
    logic signed [31:0] prev_dv;

    // Advance to the next falling edge and pop/compare any setpoint change.
    task automatic sample_cycle();
        logic signed [31:0] e;
        @(negedge clk);
        if (desired_vel !== prev_dv) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got %0d required no change from %0d", desired_vel, prev_dv);
            end else begin
                e = exp_q.pop_front();
                if (desired_vel !== e) begin
                    bad++;
                    $display("FAIL sb_value: got %0d required %0d", desired_vel, e);
                end
            end
            prev_dv = desired_vel;
        end
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            sample_cycle();
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: got %0d values pending required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Returns at the falling edge inside the cycle after the handshake edge.
    task automatic send_cmd(input logic signed [31:0] target, input logic [15:0] accel);
        int n = 0;
        cmd_if.cmd_valid      = 1'b1;
        cmd_if.cmd_target_vel = target;
        cmd_if.cmd_accel      = accel;
        while (!cmd_if.cmd_ready && n < 50) begin
            sample_cycle();
            n++;
        end
        total++;
        if (!cmd_if.cmd_ready) begin
            bad++;
            $display("FAIL send_timeout: got cmd_ready=%b required 1", cmd_if.cmd_ready);
        end
        sample_cycle();
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_no_tick();
        int n = 0;
        while (tick && n < UDIV) begin
            sample_cycle();
            n++;
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        stop_req = 1'b0;
        cmd_if.cmd_valid      = 1'b0;
        cmd_if.cmd_target_vel = '0;
        cmd_if.cmd_accel      = '0;
        prev_dv  = '0;
        repeat (3) sample_cycle();
        total++;
        if (desired_vel !== 32'sd0) begin
            bad++;
            $display("FAIL reset_dv: got %0d required 0", desired_vel);
        end
        total++;
        if ({cmd_if.cmd_ready, at_target, busy, stopping, tick} !== 5'b11000) begin
            bad++;
            $display("FAIL reset_flags: got %b required 11000",
                     {cmd_if.cmd_ready, at_target, busy, stopping, tick});
        end
        reset = 1'b0;
        sample_cycle();
    endtask

    task automatic test_ramp_up();
        exp_q.push_back(300);
        exp_q.push_back(600);
        exp_q.push_back(900);
        exp_q.push_back(1000);
        send_cmd(1000, 300);
        total++;
        if ({cmd_if.cmd_ready, busy, at_target} !== 3'b010) begin
            bad++;
            $display("FAIL load_flags: got %b required 010", {cmd_if.cmd_ready, busy, at_target});
        end
        drain("ramp_up", 4 * UDIV + 4);
        total++;
        if (desired_vel !== 1000 || at_target !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL ramp_up_end: got dv=%0d at_target=%b busy=%b required 1000 1 0",
                     desired_vel, at_target, busy);
        end
    endtask

    task automatic test_ramp_down();
        exp_q.push_back(600);
        exp_q.push_back(200);
        exp_q.push_back(-200);
        exp_q.push_back(-500);
        send_cmd(-500, 400);
        drain("ramp_down", 4 * UDIV + 4);
        total++;
        if (desired_vel !== -500 || at_target !== 1'b1) begin
            bad++;
            $display("FAIL ramp_down_end: got dv=%0d at_target=%b required -500 1", desired_vel, at_target);
        end
    endtask

    task automatic test_retarget();
        exp_q.push_back(0);
        send_cmd(0, 0);
        sample_cycle();
        total++;
        if (desired_vel !== 32'sd0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL zero_jump: got %0d required 0", desired_vel);
            exp_q.delete();
        end
        exp_q.push_back(100);
        exp_q.push_back(200);
        exp_q.push_back(300);
        send_cmd(10000, 100);
        drain("retarget_pre", 3 * UDIV + 4);
        total++;
        if ({busy, cmd_if.cmd_ready} !== 2'b11) begin
            bad++;
            $display("FAIL ramp_flags: got %b required 11", {busy, cmd_if.cmd_ready});
        end
        wait_no_tick();
        exp_q.push_back(250);
        exp_q.push_back(200);
        send_cmd(200, 50);
        drain("retarget", 2 * UDIV + 4);
        total++;
        if (desired_vel !== 200 || at_target !== 1'b1) begin
            bad++;
            $display("FAIL retarget_end: got dv=%0d at_target=%b required 200 1", desired_vel, at_target);
        end
    endtask

    task automatic test_stop();
        int n = 0;
        stop_req              = 1'b1;
        cmd_if.cmd_valid      = 1'b1;
        cmd_if.cmd_target_vel = 5000;
        cmd_if.cmd_accel      = 10;
        sample_cycle();
        cmd_if.cmd_valid = 1'b0;
        total++;
        if ({stopping, cmd_if.cmd_ready} !== 2'b10) begin
            bad++;
            $display("FAIL stop_entry: got stopping,ready=%b required 10", {stopping, cmd_if.cmd_ready});
        end
        exp_q.push_back(136);
        exp_q.push_back(72);
        exp_q.push_back(8);
        exp_q.push_back(0);
        while (exp_q.size() != 0 && n < 4 * UDIV + 4) begin
            sample_cycle();
            n++;
            total++;
            if (cmd_if.cmd_ready !== 1'b0) begin
                bad++;
                $display("FAIL stop_ready: got %b required 0", cmd_if.cmd_ready);
            end
        end
        drain("stop", 1);
        repeat (3 * UDIV) sample_cycle();
        total++;
        if (desired_vel !== 32'sd0 || stopping !== 1'b1) begin
            bad++;
            $display("FAIL stop_hold: got dv=%0d stopping=%b required 0 1", desired_vel, stopping);
        end
        stop_req = 1'b0;
        sample_cycle();
        total++;
        if ({at_target, stopping} !== 2'b10) begin
            bad++;
            $display("FAIL stop_exit: got at_target,stopping=%b required 10", {at_target, stopping});
        end
        repeat (2 * UDIV) sample_cycle();
    endtask

    task automatic test_boundary();
        exp_q.push_back(VMIN);
        send_cmd(VMIN, 0);
        sample_cycle();
        total++;
        if (desired_vel !== VMIN || exp_q.size() != 0) begin
            bad++;
            $display("FAIL min_jump: got %0d required %0d", desired_vel, VMIN);
            exp_q.delete();
        end
        for (int k = 1; k <= 8; k++)
            exp_q.push_back(VMIN + 32'(k * 65535));
        send_cmd(VMAX, 16'hFFFF);
        drain("full_swing", 8 * UDIV + 6);
        wait_no_tick();
        exp_q.push_back(VMAX - 100000);
        send_cmd(VMAX - 100000, 0);
        sample_cycle();
        total++;
        if (desired_vel !== VMAX - 100000 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL near_max_jump: got %0d required %0d", desired_vel, VMAX - 100000);
            exp_q.delete();
        end
        exp_q.push_back(VMAX - 34465);
        exp_q.push_back(VMAX);
        send_cmd(VMAX, 16'hFFFF);
        drain("to_max", 2 * UDIV + 6);
        total++;
        if (desired_vel !== VMAX || at_target !== 1'b1) begin
            bad++;
            $display("FAIL max_end: got dv=%0d at_target=%b required %0d 1", desired_vel, at_target, VMAX);
        end
        exp_q.push_back(-42);
        send_cmd(-42, 0);
        total++;
        if (desired_vel !== VMAX) begin
            bad++;
            $display("FAIL jump_early: got %0d required %0d", desired_vel, VMAX);
        end
        sample_cycle();
        total++;
        if (desired_vel !== -42 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL jump_m42: got %0d required -42", desired_vel);
            exp_q.delete();
        end
    endtask

    task automatic test_async_reset();
        int last = -1;
        int nt   = 0;
        exp_q.push_back(-32);
        exp_q.push_back(-22);
        send_cmd(5000, 10);
        drain("pre_reset", 2 * UDIV + 4);
        #3 reset = 1'b1;
        #1;
        total++;
        if (desired_vel !== 32'sd0) begin
            bad++;
            $display("FAIL async_dv: got %0d required 0", desired_vel);
        end
        total++;
        if ({cmd_if.cmd_ready, at_target, busy, stopping, tick} !== 5'b11000) begin
            bad++;
            $display("FAIL async_flags: got %b required 11000",
                     {cmd_if.cmd_ready, at_target, busy, stopping, tick});
        end
        prev_dv = '0;
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 6 * UDIV; c++) begin
            sample_cycle();
            if (tick) begin
                if (last >= 0) begin
                    total++;
                    if (c - last != UDIV) begin
                        bad++;
                        $display("FAIL tick_spacing: got %0d required %0d", c - last, UDIV);
                    end
                end
                last = c;
                nt++;
            end
        end
        total++;
        if (nt < 5) begin
            bad++;
            $display("FAIL tick_count: got %0d required at least 5", nt);
        end
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_ramp_down();
        test_retarget();
        test_stop();
        test_boundary();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
